wb_trace_fifo: RTL and testbench



---
 rtl/wb_trace_fifo.sv | 104 ++++++++++
 tb/tb_wb_trace_fifo.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_trace_fifo.sv
// Write-back trace capture FIFO: queues every non-$0 register write from the WB stage
// and presents it show-ahead over a valid/ready port, counting captures lost to overflow.
module wb_trace_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  reg_write,
  input  logic [4:0]            wb_rd,
  input  logic [31:0]           result,
  input  logic                  clear,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4:0]            out_rd,
  output logic [31:0]           out_data,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow,
  output logic [15:0]           drop_cnt
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE = (DEPTH_LOG2 + 1)'(1);

  logic [36:0]           mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic [15:0]           drop_cnt_q, drop_cnt_d;

  logic push_req, full, empty, pop, push, drop, wr_en;
  logic [36:0] head;

  // count never exceeds DEPTH, so its top bit alone marks the full condition
  assign full     = count_q[DEPTH_LOG2];
  assign empty    = (count_q == '0);
  assign push_req = reg_write && (wb_rd != 5'd0);
  assign pop      = !empty && out_ready;
  assign push     = push_req && (!full || pop);
  assign drop     = push_req && full && !pop;
  assign wr_en    = push && !clear;
  assign head     = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    if (clear) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
      drop_cnt_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      if (push && !pop)      count_d = count_q + CNT_ONE;
      else if (pop && !push) count_d = count_q - CNT_ONE;
      if (drop) begin
        overflow_d = 1'b1;
        if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Storage needs no reset; a full-and-popping push overwrites the slot being read out
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= {wb_rd, result};
  end

  always_comb begin
    out_valid = !empty;
    out_rd    = 5'd0;
    out_data  = 32'd0;
    if (!empty) begin
      out_rd   = head[36:32];
      out_data = head[31:0];
    end
  end

  assign count    = count_q;
  assign overflow = overflow_q;
  assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_wb_trace_fifo.sv
// Bench for wb_trace_fifo: a table of directed cycles plus a queue-based reference model
// that checks every output on every cycle, with hand-written full/wrap/clear/reset sequences.
module tb_wb_trace_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic        reg_write;
  logic [4:0]  wb_rd;
  logic [31:0] result;
  logic        clear;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_rd;
  logic [31:0] out_data;
  logic [4:0]  count;
  logic        overflow;
  logic [15:0] drop_cnt;

  wb_trace_fifo #(.DEPTH_LOG2(4)) dut (
    .clk(clk), .rst(rst), .reg_write(reg_write), .wb_rd(wb_rd), .result(result),
    .clear(clear), .out_valid(out_valid), .out_ready(out_ready), .out_rd(out_rd),
    .out_data(out_data), .count(count), .overflow(overflow), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [36:0] sb[$];
  bit          m_ovf = 1'b0;
  logic [15:0] m_drop = 16'd0;
  logic [31:0] last_pop_data;

  typedef struct {
    bit          rw;
    logic [4:0]  rd;
    logic [31:0] data;
    bit          rdy;
    int          e_cnt;
    bit          e_valid;
    logic [4:0]  e_rd;
    logic [31:0] e_data;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Checks outputs against the model mid-cycle, then advances the model with this cycle's inputs.
  task automatic cycle();
    bit preq, full, pop;
    logic [36:0] h;
    @(negedge clk);
    chk("count", 32'(count), 32'(sb.size()));
    chk("out_valid", 32'(out_valid), 32'(sb.size() != 0));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
    if (sb.size() != 0) begin
      h = sb[0];
      chk("out_rd", 32'(out_rd), 32'(h[36:32]));
      chk("out_data", out_data, h[31:0]);
    end else begin
      chk("out_rd_empty", 32'(out_rd), 32'd0);
      chk("out_data_empty", out_data, 32'd0);
    end
    preq = reg_write && (wb_rd != 5'd0);
    full = (sb.size() == 16);
    pop  = (sb.size() != 0) && out_ready;
    if (clear) begin
      sb.delete();
      m_ovf  = 1'b0;
      m_drop = 16'd0;
    end else begin
      if (pop) begin
        last_pop_data = out_data;
        void'(sb.pop_front());
      end
      if (preq) begin
        if (!full || pop) sb.push_back({wb_rd, result});
        else begin
          m_ovf = 1'b1;
          if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit rw, input logic [4:0] rd, input logic [31:0] data,
                       input bit rdy, input bit clr);
    reg_write = rw;
    wb_rd     = rd;
    result    = data;
    out_ready = rdy;
    clear     = clr;
    cycle();
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) drive(1'b0, 5'd0, 32'd0, rdy, 1'b0);
  endtask

  initial begin
    tbl[0]  = '{1, 5'd0,  32'hDEADBEEF, 0, 0, 0, 5'd0,  32'h0};
    tbl[1]  = '{1, 5'd0,  32'hDEADBEEF, 0, 0, 0, 5'd0,  32'h0};
    tbl[2]  = '{1, 5'd0,  32'hDEADBEEF, 0, 0, 0, 5'd0,  32'h0};
    tbl[3]  = '{1, 5'd8,  32'h00000011, 0, 0, 0, 5'd0,  32'h0};
    tbl[4]  = '{1, 5'd9,  32'h00000022, 0, 1, 1, 5'd8,  32'h11};
    tbl[5]  = '{1, 5'd31, 32'hFFFFFFFF, 0, 2, 1, 5'd8,  32'h11};
    tbl[6]  = '{0, 5'd0,  32'h0,        0, 3, 1, 5'd8,  32'h11};
    tbl[7]  = '{0, 5'd0,  32'h0,        1, 3, 1, 5'd8,  32'h11};
    tbl[8]  = '{0, 5'd0,  32'h0,        1, 2, 1, 5'd9,  32'h22};
    tbl[9]  = '{0, 5'd0,  32'h0,        1, 1, 1, 5'd31, 32'hFFFFFFFF};
    tbl[10] = '{0, 5'd0,  32'h0,        1, 0, 0, 5'd0,  32'h0};

    rst = 1'b1; reg_write = 1'b0; wb_rd = 5'd0; result = 32'd0; clear = 1'b0; out_ready = 1'b0;
    #3;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_rd", 32'(out_rd), 32'd0);
    chk("rst_data", out_data, 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_drop", 32'(drop_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // filter and basic ordering
    for (int i = 0; i < 11; i++) begin
      reg_write = tbl[i].rw; wb_rd = tbl[i].rd; result = tbl[i].data;
      out_ready = tbl[i].rdy; clear = 1'b0;
      #1;
      chk($sformatf("tbl%0d_count", i), 32'(count), 32'(tbl[i].e_cnt));
      chk($sformatf("tbl%0d_valid", i), 32'(out_valid), 32'(tbl[i].e_valid));
      chk($sformatf("tbl%0d_rd", i), 32'(out_rd), 32'(tbl[i].e_rd));
      chk($sformatf("tbl%0d_data", i), out_data, tbl[i].e_data);
      chk($sformatf("tbl%0d_ovf", i), 32'(overflow), 32'd0);
      cycle();
    end

    // full and overflow
    for (int i = 1; i <= 18; i++) drive(1'b1, 5'(i), 32'(i), 1'b0, 1'b0);
    #1;
    chk("full_count", 32'(count), 32'd16);
    chk("full_overflow", 32'(overflow), 32'd1);
    chk("full_drop", 32'(drop_cnt), 32'd2);
    idle(17, 1'b1);
    chk("drained_last", last_pop_data, 32'd16);
    chk("drained_count", 32'(count), 32'd0);

    // simultaneous push and pop while full
    drive(1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) drive(1'b1, 5'((i % 31) + 1), $urandom, 1'b0, 1'b0);
    drive(1'b1, 5'd5, 32'hA5A5A5A5, 1'b1, 1'b0);
    #1;
    chk("pp_count", 32'(count), 32'd16);
    chk("pp_overflow", 32'(overflow), 32'd0);
    idle(17, 1'b1);
    chk("pp_last", last_pop_data, 32'hA5A5A5A5);

    // streaming across pointer wrap with a toggling consumer
    for (int i = 0; i < 40; i++)
      drive(1'b1, 5'($urandom_range(31, 1)), $urandom, (i % 2) == 0, 1'b0);
    idle(25, 1'b1);
    chk("wrap_empty", 32'(out_valid), 32'd0);

    // overflow then clear together with a push
    for (int i = 0; i < 18; i++) drive(1'b1, 5'd7, 32'(100 + i), 1'b0, 1'b0);
    drive(1'b1, 5'd12, 32'hCAFEF00D, 1'b0, 1'b1);
    #1;
    chk("clr_count", 32'(count), 32'd0);
    chk("clr_overflow", 32'(overflow), 32'd0);
    chk("clr_drop", 32'(drop_cnt), 32'd0);
    chk("clr_valid", 32'(out_valid), 32'd0);
    idle(2, 1'b1);

    // asynchronous reset between clock edges
    for (int i = 0; i < 7; i++) drive(1'b1, 5'(20 + i), 32'(i * 3), 1'b0, 1'b0);
    reg_write = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_count", 32'(count), 32'd0);
    sb.delete();
    m_ovf = 1'b0;
    m_drop = 16'd0;
    #1;
    rst = 1'b0;
    drive(1'b1, 5'd3, 32'h1234, 1'b0, 1'b0);
    #1;
    chk("post_rst_count", 32'(count), 32'd1);
    chk("post_rst_rd", 32'(out_rd), 32'd3);
    chk("post_rst_data", out_data, 32'h1234);
    idle(2, 1'b1);
    chk("post_rst_drained", 32'(count), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
